xge_pkt_rx_reader: RTL
======================

# xge_pkt_rx_reader

Consumer for the MAC's 64-bit packet receive interface in the 156.25 MHz domain. Waits for `pkt_rx_avail`, drives `pkt_rx_ren` to drain one frame word by word, and absorbs the one-cycle read latency in a small FIFO. Re-presents each word on a valid/ready stream with back-pressure. Checks SOP/EOP framing and keeps frame, error and byte statistics.

## Interface
- `FIFO_DEPTH`, 4: output buffer entries; must be a power of two and at least 2.
- `CNT_W`, 32: width of each statistics counter.
- `clk_156m25` in 1: core clock.
- `reset_156m25_n` in 1: asynchronous, active-low reset.
- `pkt_rx_avail` in 1: the MAC holds at least one complete frame.
- `pkt_rx_ren` out 1: read enable to the MAC.
- `pkt_rx_val` in 1: word valid; answers `pkt_rx_ren` from the previous cycle.
- `pkt_rx_data` in 64, `pkt_rx_sop` in 1, `pkt_rx_eop` in 1: word data and frame delimiters.
- `pkt_rx_mod` in 3: valid bytes in the EOP word; 0 means 8.
- `pkt_rx_err` in 1: frame error, qualified by EOP.
- `out_valid` out 1, `out_ready` in 1: output stream handshake.
- `out_data` out 64, `out_sop` out 1, `out_eop` out 1, `out_mod` out 3, `out_err` out 1: output word fields.
- `clr_stats` in 1: synchronous clear of the counters and `proto_err`.
- `frame_cnt` out CNT_W: frames completed.
- `err_frame_cnt` out CNT_W: frames whose EOP word had `err` set.
- `byte_cnt` out CNT_W: bytes received.
- `proto_err` out 1: sticky framing-violation flag.

## Operation
- FSM states IDLE and READ.
  - IDLE → READ when `pkt_rx_avail`=1.
  - READ → IDLE in the cycle in which `pkt_rx_val`=1 and `pkt_rx_eop`=1.
- `pkt_rx_ren` = (state==READ) AND NOT(`pkt_rx_val` AND `pkt_rx_eop`) AND (occ + ren_q < FIFO_DEPTH).
  - occ is current FIFO occupancy.
  - ren_q is `pkt_rx_ren` registered from the previous cycle.
- Every `pkt_rx_val`=1 word is pushed unconditionally, with {data, sop, eop, mod, err}. The ren rule above guarantees the push never overflows.
- Pop occurs when `out_valid` AND `out_ready`. `out_*` show the FIFO head; `out_valid` = FIFO not empty.
- `out_err` follows `pkt_rx_err` only on EOP words; it is 0 on all other words.
- Framing check: an in-frame flag is set by SOP and cleared by EOP. `proto_err` sets on either of:
  - SOP while in-frame;
  - a non-SOP word while not in-frame.
  - Words are forwarded unchanged regardless.
- If push and pop happen in the same cycle, occupancy is unchanged.

## Timing
- `pkt_rx_avail` rising → `pkt_rx_ren` high on the next cycle. It is combinational once in READ.
- Data arrives one cycle after ren. First `out_valid` appears 1 cycle after the first `pkt_rx_val`, because the FIFO is registered.
- With `out_ready` held at 1, throughput is one word per cycle. In steady state the FIFO never holds more than 2 words.
- With `out_ready`=0, ren deasserts so that occupancy never exceeds FIFO_DEPTH. One in-flight word may still land after ren drops.
- Counters update 1 cycle after the EOP word is pushed, and saturate at all-ones. `clr_stats` has priority over an update in the same cycle.
- Reset values:
  - state=IDLE;
  - `pkt_rx_ren`=0, `out_valid`=0;
  - `out_data`/`out_sop`/`out_eop`/`out_mod`/`out_err`=0;
  - all counters=0, `proto_err`=0;
  - FIFO empty, ren_q=0.
- A reset asserted mid-frame discards FIFO contents and the partial frame. After reset, the reader restarts from IDLE.

## Configuration
- `XGE_RX_READER_STATS_EN`
  - Defined: `frame_cnt`, `err_frame_cnt`, `byte_cnt` and `proto_err` are implemented as described.
  - Undefined: those four outputs are tied to 0, and no counter or framing-check logic is instantiated. The data path is unchanged.

## Test plan
- Single 3-word frame, `out_ready`=1, last `mod`=5:
  - `pkt_rx_ren` is high for exactly the 3 read cycles;
  - output words in order with sop on word 1 and eop+mod=5 on word 3;
  - `byte_cnt`=21, `frame_cnt`=1.
- 10-word frame with `out_ready`=0 for cycles 2–12:
  - occupancy ≤ 4, no data loss;
  - ren resumes within 1 cycle of ready returning;
  - all 10 words are delivered in order.
- Frame with `pkt_rx_err`=1 on EOP and `mod`=0:
  - `out_err`=1 on the EOP word only;
  - `err_frame_cnt`=1, `byte_cnt` += 8 × words.
- Two back-to-back frames with `pkt_rx_avail` held high: FSM returns through IDLE, both frames are delivered, `frame_cnt`=2, `proto_err`=0.
- SOP injected mid-frame: `proto_err`=1 and stays set until `clr_stats`, which zeros all counters.
- `reset_156m25_n` asserted during word 2 of a 5-word frame:
  - all outputs return to reset values immediately;
  - the next frame is read cleanly.

Source files
------------

// File: rtl/xge_pkt_rx_reader.sv
// Drains frames from the 10G MAC packet receive interface and re-presents them on a valid/ready stream.
// Latency: first out_valid 1 cycle after the first pkt_rx_val; pkt_rx_ren is high the cycle after pkt_rx_avail rises.
// Backpressure: pkt_rx_ren is throttled so that buffered plus in-flight words never exceed FIFO_DEPTH.
//
// Ports: clk_156m25/reset_156m25_n (async active-low); pkt_rx_* MAC read side; out_* output stream;
// clr_stats, frame_cnt, err_frame_cnt, byte_cnt, proto_err statistics.
// Optional statistics and framing check are enabled by defining XGE_RX_READER_STATS_EN;
// without it those outputs are tied to 0 and the data path is identical.
module xge_pkt_rx_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25_n,
    input  logic             pkt_rx_avail,
    output logic             pkt_rx_ren,
    input  logic             pkt_rx_val,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic [2:0]       pkt_rx_mod,
    input  logic             pkt_rx_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic [2:0]       out_mod,
    output logic             out_err,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_frame_cnt,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             proto_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } word_t;

    typedef enum logic {IDLE, READ} state_t;

    state_t        state;
    logic          ren_q;
    word_t         mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_sum;
    logic          push;
    logic          pop;
    word_t         head;

    assign push = pkt_rx_val;
    assign pop  = out_valid && out_ready;

    // A read issued last cycle lands this cycle, so it has to be counted as
    // already occupying a slot when deciding whether to issue another one.
    assign occ_sum    = occ + {{AW{1'b0}}, ren_q};
    assign pkt_rx_ren = (state == READ) && !(pkt_rx_val && pkt_rx_eop)
                        && (occ_sum < OW'(FIFO_DEPTH));

    assign out_valid = (occ != '0);
    assign head      = mem[rd_ptr];
    assign out_data  = head.data;
    assign out_sop   = head.sop;
    assign out_eop   = head.eop;
    assign out_mod   = head.mod;
    assign out_err   = head.err;

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state <= IDLE;
            ren_q <= 1'b0;
        end else begin
            ren_q <= pkt_rx_ren;
            case (state)
                IDLE:    if (pkt_rx_avail) state <= READ;
                READ:    if (pkt_rx_val && pkt_rx_eop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                // err is only meaningful on the EOP word
                mem[wr_ptr] <= '{data: pkt_rx_data, sop: pkt_rx_sop, eop: pkt_rx_eop,
                                 mod: pkt_rx_mod, err: pkt_rx_err && pkt_rx_eop};
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      occ <= occ + OW'(1);
            else if (!push && pop) occ <= occ - OW'(1);
        end
    end

`ifdef XGE_RX_READER_STATS_EN
    logic           in_frame;
    logic [3:0]     word_bytes;
    logic [CNT_W:0] byte_sum;

    assign word_bytes = (pkt_rx_eop && pkt_rx_mod != 3'd0) ? {1'b0, pkt_rx_mod} : 4'd8;
    assign byte_sum   = {1'b0, byte_cnt} + (CNT_W+1)'(word_bytes);

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            in_frame      <= 1'b0;
            frame_cnt     <= '0;
            err_frame_cnt <= '0;
            byte_cnt      <= '0;
            proto_err     <= 1'b0;
        end else begin
            if (pkt_rx_val)
                in_frame <= pkt_rx_sop ? !pkt_rx_eop : (in_frame && !pkt_rx_eop);
            if (clr_stats) begin
                frame_cnt     <= '0;
                err_frame_cnt <= '0;
                byte_cnt      <= '0;
                proto_err     <= 1'b0;
            end else if (pkt_rx_val) begin
                byte_cnt <= byte_sum[CNT_W] ? '1 : byte_sum[CNT_W-1:0];
                if (pkt_rx_eop && frame_cnt != '1)
                    frame_cnt <= frame_cnt + CNT_W'(1);
                if (pkt_rx_eop && pkt_rx_err && err_frame_cnt != '1)
                    err_frame_cnt <= err_frame_cnt + CNT_W'(1);
                // SOP inside a frame, or a non-SOP word outside one
                if (pkt_rx_sop == in_frame)
                    proto_err <= 1'b1;
            end
        end
    end
`else
    logic stats_unused;
    assign stats_unused  = clr_stats;
    assign frame_cnt     = '0;
    assign err_frame_cnt = '0;
    assign byte_cnt      = '0;
    assign proto_err     = 1'b0;
`endif

endmodule
